// File: rtl/seq_detect_param_if.sv
// Bus bundle for seq_detect_param: serial data, pattern control and match outputs.
// The pattern_mask signal exists only when SEQ_DETECT_MASK_EN is defined.
interface seq_detect_param_if #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8
);
  logic             datain;
  logic             valid_in;
  logic             pattern_load;
  logic [PAT_W-1:0] pattern_in;
`ifdef SEQ_DETECT_MASK_EN
  logic [PAT_W-1:0] pattern_mask;
`endif
  logic             overlap_en;
  logic             count_clr;
  logic             match;
  logic [CNT_W-1:0] match_count;

  // Stimulus side: drives data and control, observes results.
  modport master (
`ifdef SEQ_DETECT_MASK_EN
    output pattern_mask,
`endif
    output datain, valid_in, pattern_load, pattern_in, overlap_en, count_clr,
    input  match, match_count
  );

  // Detector side.
  modport slave (
`ifdef SEQ_DETECT_MASK_EN
    input  pattern_mask,
`endif
    input  datain, valid_in, pattern_load, pattern_in, overlap_en, count_clr,
    output match, match_count
  );
endinterface

// File: rtl/seq_detect_param.sv
// Serial pattern detector with loadable PAT_W-bit pattern, selectable
// overlapping / non-overlapping detection and a saturating match counter.
// Optional feature: define SEQ_DETECT_MASK_EN to add a per-bit care mask
// (pattern_mask); a 0 mask bit makes that pattern position don't-care.
module seq_detect_param #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  seq_detect_param_if.slave bus
);

  localparam int                FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [PAT_W-1:0]  hist_q,  hist_d;
  logic [FILL_W-1:0] fill_q,  fill_d;
  logic [PAT_W-1:0]  pat_q,   pat_d;
  logic              match_q, match_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PAT_W-1:0]  care;
  logic [PAT_W-1:0]  window;
  logic              hit;

`ifdef SEQ_DETECT_MASK_EN
  logic [PAT_W-1:0]  mask_q, mask_d;

  // Mask register: reloaded together with the pattern.
  always_comb begin
    mask_d = mask_q;
    if (bus.pattern_load) mask_d = bus.pattern_mask;
  end

  // Mask state; comes out of reset comparing every bit.
  always_ff @(posedge clock) begin
    if (reset) mask_q <= '1;
    else       mask_q <= mask_d;
  end

  assign care = mask_q;
`else
  assign care = '1;
`endif

  // Hit detection: the incoming bit completes a full window equal to the
  // pattern on the cared-for positions. A load on the same edge wins.
  always_comb begin
    window = {hist_q[PAT_W-2:0], bus.datain};
    hit    = bus.valid_in && !bus.pattern_load && (fill_q >= FILL_ARM) &&
             (((window ^ pat_q) & care) == '0);
  end

  // Next-state for history, fill level, pattern, match pulse and counter.
  always_comb begin
    // NOTE: every variable gets a default here so no path can infer a latch.
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    match_d = hit;
    count_d = count_q;

    if (bus.pattern_load) begin
      pat_d  = bus.pattern_in;
      hist_d = '0;
      fill_d = '0;
    end else if (bus.valid_in) begin
      hist_d = window;
      if (hit && !bus.overlap_en) fill_d = '0;
      else if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
    end

    // A clear coinciding with a hit still counts that hit.
    if (bus.count_clr)                count_d = hit ? CNT_W'(1) : '0;
    else if (hit && count_q != CNT_MAX) count_d = count_q + 1'b1;
  end

  // State register with synchronous reset that overrides all other controls.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      match_q <= 1'b0;
      count_q <= '0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      match_q <= match_d;
      count_q <= count_d;
    end
  end

  assign bus.match       = match_q;
  assign bus.match_count = count_q;

endmodule
